reg_wb_scheduler: RTL and testbench

- Owns the register file's single write port and its register-to-register hazard state.
- Arbitrates register file writes between two sources:
  - the in-order pipeline writeback (pipe WB);
  - a long-latency unit (LU: mul/div/miss load) with a valid/ready handshake.
- Keeps a 32-bit scoreboard of registers with LU writes pending, and stalls issue on hazards.
- Sits between the WB stage, the LU result port and the register file write inputs (RegWrite/RDaddr/RDdata).

---
 rtl/reg_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 60 ++++++
 rtl/reg_wb_scheduler.sv | 118 +++++++++++
 tb/tb_reg_wb_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared register-file widths, constants and writeback request type
package reg_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-LU-write scoreboard, outstanding counter and issue stall
module reg_scoreboard
    import reg_pkg::*;
#(
    parameter int ADDR_W          = reg_pkg::ADDR_W,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                iss_valid_i,
    input  logic [ADDR_W-1:0]   iss_rs1_i,
    input  logic [ADDR_W-1:0]   iss_rs2_i,
    input  logic [ADDR_W-1:0]   iss_rd_i,
    input  logic                iss_long_i,
    input  logic                clr_i,
    input  logic [ADDR_W-1:0]   clr_rd_i,
    output logic                stall_o,
    output logic [NUM_REGS-1:0] busy_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    cnt_q;
    logic                accept;

    // Stall looks only at registered state, so a same-cycle clear does not unblock issue.
    assign stall_o = iss_valid_i & (busy_q[iss_rs1_i] | busy_q[iss_rs2_i] | busy_q[iss_rd_i]
                                    | (iss_long_i & (cnt_q == CNT_MAX)));
    assign accept  = iss_valid_i & ~stall_o & iss_long_i;
    assign busy_o  = busy_q;

    always_comb begin
        busy_nxt = busy_q;
        if (clr_i) begin
            busy_nxt[clr_rd_i] = 1'b0;
        end
        if (accept && (iss_rd_i != REG_ZERO)) begin
            busy_nxt[iss_rd_i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_nxt;
            case ({accept, clr_i})
                2'b10:   if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                2'b01:   if (cnt_q != '0)      cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/reg_wb_scheduler.sv
// rtl/reg_wb_scheduler.sv - register file write-port arbiter (pipe WB vs LU); option WB_STARVE_GUARD_EN
module reg_wb_scheduler
    import reg_pkg::*;
#(
    parameter int DATA_W          = reg_pkg::DATA_W,
    parameter int ADDR_W          = reg_pkg::ADDR_W,
    parameter int MAX_OUTSTANDING = 4
`ifdef WB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT    = 8
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                iss_valid_i,
    input  logic [ADDR_W-1:0]   iss_rs1_i,
    input  logic [ADDR_W-1:0]   iss_rs2_i,
    input  logic [ADDR_W-1:0]   iss_rd_i,
    input  logic                iss_long_i,
    output logic                iss_stall_o,
    input  logic                pipe_wb_valid_i,
    input  logic [ADDR_W-1:0]   pipe_wb_rd_i,
    input  logic [DATA_W-1:0]   pipe_wb_data_i,
    input  logic                lu_wb_valid_i,
    input  logic [ADDR_W-1:0]   lu_wb_rd_i,
    input  logic [DATA_W-1:0]   lu_wb_data_i,
    output logic                lu_wb_ready_o,
    output logic                rf_we_o,
    output logic [ADDR_W-1:0]   rf_addr_o,
    output logic [DATA_W-1:0]   rf_data_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                pipe_hold_o
);

    logic    lu_grant;
    wb_req_t win;

    assign lu_grant = lu_wb_valid_i & lu_wb_ready_o;

    reg_scoreboard #(
        .ADDR_W          (ADDR_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .iss_valid_i (iss_valid_i),
        .iss_rs1_i   (iss_rs1_i),
        .iss_rs2_i   (iss_rs2_i),
        .iss_rd_i    (iss_rd_i),
        .iss_long_i  (iss_long_i),
        .clr_i       (lu_grant),
        .clr_rd_i    (lu_wb_rd_i),
        .stall_o     (iss_stall_o),
        .busy_o      (busy_o)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q;
    logic          hold_q;

    // While hold is up the pipe is blanked upstream, so the LU owns the port.
    assign lu_wb_ready_o = lu_wb_valid_i & (~pipe_wb_valid_i | hold_q);
    assign pipe_hold_o   = hold_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            if (!lu_wb_valid_i || lu_grant) begin
                starve_q <= '0;
            end else if (starve_q != SW'(STARVE_LIMIT)) begin
                starve_q <= starve_q + 1'b1;
            end
            if (lu_grant) begin
                hold_q <= 1'b0;
            end else if (lu_wb_valid_i && (starve_q == SW'(STARVE_LIMIT - 1))) begin
                hold_q <= 1'b1;
            end
        end
    end
`else
    assign lu_wb_ready_o = lu_wb_valid_i & ~pipe_wb_valid_i;
    assign pipe_hold_o   = 1'b0;
`endif

    always_comb begin
        win = '0;
        if (lu_grant) begin
            win = '{valid: 1'b1, rd: lu_wb_rd_i, data: lu_wb_data_i};
        end else if (pipe_wb_valid_i) begin
            win = '{valid: 1'b1, rd: pipe_wb_rd_i, data: pipe_wb_data_i};
        end
    end

    // Writes to x0 still consume the grant but never assert the write enable.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rf_we_o   <= 1'b0;
            rf_addr_o <= '0;
            rf_data_o <= '0;
        end else begin
            rf_we_o <= win.valid && (win.rd != REG_ZERO);
            if (win.valid) begin
                rf_addr_o <= win.rd;
                rf_data_o <= win.data;
            end
        end
    end

`ifndef SYNTHESIS
    a_pipe_wb_not_busy: assert property (@(posedge clk_i) disable iff (!rst_i)
        pipe_wb_valid_i |-> !busy_o[pipe_wb_rd_i]);
`endif

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// tb/tb_reg_wb_scheduler.sv - scoreboard bench for reg_wb_scheduler
module tb_reg_wb_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        iss_valid_i = 1'b0;
    logic [4:0]  iss_rs1_i = '0, iss_rs2_i = '0, iss_rd_i = '0;
    logic        iss_long_i = 1'b0;
    logic        iss_stall_o;
    logic        pipe_wb_valid_i = 1'b0;
    logic [4:0]  pipe_wb_rd_i = '0;
    logic [63:0] pipe_wb_data_i = '0;
    logic        lu_wb_valid_i = 1'b0;
    logic [4:0]  lu_wb_rd_i = '0;
    logic [63:0] lu_wb_data_i = '0;
    logic        lu_wb_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [63:0] rf_data_o;
    logic [31:0] busy_o;
    logic        pipe_hold_o;

    int tests = 0;
    int fails = 0;
    logic [68:0] exp_q[$];

    reg_wb_scheduler dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .iss_valid_i     (iss_valid_i),
        .iss_rs1_i       (iss_rs1_i),
        .iss_rs2_i       (iss_rs2_i),
        .iss_rd_i        (iss_rd_i),
        .iss_long_i      (iss_long_i),
        .iss_stall_o     (iss_stall_o),
        .pipe_wb_valid_i (pipe_wb_valid_i),
        .pipe_wb_rd_i    (pipe_wb_rd_i),
        .pipe_wb_data_i  (pipe_wb_data_i),
        .lu_wb_valid_i   (lu_wb_valid_i),
        .lu_wb_rd_i      (lu_wb_rd_i),
        .lu_wb_data_i    (lu_wb_data_i),
        .lu_wb_ready_o   (lu_wb_ready_o),
        .rf_we_o         (rf_we_o),
        .rf_addr_o       (rf_addr_o),
        .rf_data_o       (rf_data_o),
        .busy_o          (busy_o),
        .pipe_hold_o     (pipe_hold_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic lng);
        iss_valid_i = 1'b1; iss_rs1_i = rs1; iss_rs2_i = rs2; iss_rd_i = rd; iss_long_i = lng;
    endtask

    task automatic no_issue();
        iss_valid_i = 1'b0; iss_long_i = 1'b0;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [63:0] d);
        pipe_wb_valid_i = 1'b1; pipe_wb_rd_i = rd; pipe_wb_data_i = d;
    endtask

    task automatic lu(input logic [4:0] rd, input logic [63:0] d);
        lu_wb_valid_i = 1'b1; lu_wb_rd_i = rd; lu_wb_data_i = d;
    endtask

    // Monitor: every write-enable pulse must match the oldest expected write.
    always @(negedge clk_i) begin
        if (rst_i && rf_we_o) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rf_write_unexpected: got addr %0d data %0h expected no write",
                         rf_addr_o, rf_data_o);
            end else begin
                logic [68:0] e;
                e = exp_q.pop_front();
                if ({rf_addr_o, rf_data_o} !== e) begin
                    fails++;
                    $display("FAIL rf_write: got addr %0d data %0h expected addr %0d data %0h",
                             rf_addr_o, rf_data_o, e[68:64], e[63:0]);
                end
            end
        end
    end

    initial begin
        step(); step();
        chk("reset_we",    rf_we_o,       0);
        chk("reset_addr",  rf_addr_o,     0);
        chk("reset_data",  rf_data_o,     0);
        chk("reset_busy",  busy_o,        0);
        chk("reset_hold",  pipe_hold_o,   0);
        chk("reset_ready", lu_wb_ready_o, 0);
        rst_i = 1'b1;
        step();

        // Plain pipe writeback, one-cycle latency.
        pipe(5, 64'hDEAD);
        exp_q.push_back({5'd5, 64'hDEAD});
        settle();
        chk("pipe_pre_we", rf_we_o, 0);
        step();
        pipe_wb_valid_i = 1'b0;
        settle();
        chk("pipe_we", rf_we_o, 1);
        step();
        chk("pipe_we_drop", rf_we_o, 0);

        // RAW hazard on an LU destination.
        issue(1, 2, 7, 1'b1);
        settle();
        chk("long7_accept", iss_stall_o, 0);
        step();
        issue(7, 2, 8, 1'b0);
        settle();
        chk("raw7_stall", iss_stall_o, 1);
        chk("busy7_set",  busy_o[7],   1);
        step();
        chk("raw7_stall_hold", iss_stall_o, 1);
        lu(7, 64'h77);
        exp_q.push_back({5'd7, 64'h77});
        settle();
        chk("lu7_ready",         lu_wb_ready_o, 1);
        chk("raw7_stall_grant",  iss_stall_o,   1);
        step();
        lu_wb_valid_i = 1'b0;
        settle();
        chk("raw7_unstall", iss_stall_o, 0);
        chk("busy7_clr",    busy_o[7],   0);
        no_issue();
        step();

        // Same-cycle contention: pipe wins, LU follows.
        issue(0, 0, 4, 1'b1);
        step();
        no_issue();
        pipe(3, 64'h33);
        lu(4, 64'h44);
        exp_q.push_back({5'd3, 64'h33});
        settle();
        chk("contend_ready", lu_wb_ready_o, 0);
        step();
        pipe_wb_valid_i = 1'b0;
        exp_q.push_back({5'd4, 64'h44});
        settle();
        chk("lu4_ready",   lu_wb_ready_o, 1);
        chk("busy4_still", busy_o[4],     1);
        step();
        lu_wb_valid_i = 1'b0;
        settle();
        chk("busy4_clr", busy_o[4], 0);

        // Outstanding limit.
        for (int r = 10; r < 14; r++) begin
            issue(0, 0, 5'(r), 1'b1);
            settle();
            chk("fill_accept", iss_stall_o, 0);
            step();
        end
        issue(0, 0, 14, 1'b1);
        settle();
        chk("fifth_stall", iss_stall_o, 1);
        no_issue();
        step();
        chk("busy14_unset", busy_o[14], 0);
        lu(10, 64'hA0);
        exp_q.push_back({5'd10, 64'hA0});
        step();
        lu(11, 64'hB0);
        exp_q.push_back({5'd11, 64'hB0});
        issue(0, 0, 14, 1'b1);
        settle();
        chk("grant_issue_accept", iss_stall_o, 0);
        step();
        lu_wb_valid_i = 1'b0;
        issue(0, 0, 15, 1'b1);
        settle();
        chk("refill_accept", iss_stall_o, 0);
        step();
        issue(0, 0, 16, 1'b1);
        settle();
        chk("full_again_stall", iss_stall_o, 1);
        chk("busy_after_fill", busy_o, 32'h0000_F000 | 32'h0000_C000 & 32'h0000_F000);
        no_issue();
        for (int r = 12; r < 16; r++) begin
            lu(5'(r), 64'(r) << 4);
            exp_q.push_back({5'(r), 64'(r) << 4});
            step();
        end
        lu_wb_valid_i = 1'b0;
        settle();
        chk("busy_drained", busy_o, 0);

        // Register zero: never busy, LU write dropped.
        issue(0, 0, 0, 1'b1);
        settle();
        chk("long0_accept", iss_stall_o, 0);
        step();
        no_issue();
        settle();
        chk("long0_busy", busy_o, 0);
        lu(0, 64'h99);
        settle();
        chk("lu0_ready", lu_wb_ready_o, 1);
        step();
        lu_wb_valid_i = 1'b0;
        settle();
        chk("lu0_no_we",   rf_we_o, 0);
        chk("lu0_busy",    busy_o,  0);
        issue(0, 0, 9, 1'b1);
        settle();
        chk("cnt_back_zero_accept", iss_stall_o, 0);
        step();
        no_issue();
        lu(9, 64'h9);
        exp_q.push_back({5'd9, 64'h9});
        step();
        lu_wb_valid_i = 1'b0;

`ifdef WB_STARVE_GUARD_EN
        // Starvation guard: LU forced through after the limit.
        lu(21, 64'h2121);
        for (int i = 0; i < 8; i++) begin
            pipe(20, 64'(i));
            exp_q.push_back({5'd20, 64'(i)});
            settle();
            chk("starve_ready_low", lu_wb_ready_o, 0);
            step();
        end
        chk("hold_set", pipe_hold_o, 1);
        pipe_wb_valid_i = 1'b0;
        exp_q.push_back({5'd21, 64'h2121});
        settle();
        chk("hold_ready", lu_wb_ready_o, 1);
        step();
        lu_wb_valid_i = 1'b0;
        settle();
        chk("hold_drop", pipe_hold_o, 0);
`else
        lu(21, 64'h2121);
        for (int i = 0; i < 10; i++) begin
            pipe(20, 64'(i));
            exp_q.push_back({5'd20, 64'(i)});
            step();
        end
        chk("no_guard_hold", pipe_hold_o, 0);
        pipe_wb_valid_i = 1'b0;
        exp_q.push_back({5'd21, 64'h2121});
        step();
        lu_wb_valid_i = 1'b0;
`endif

        // Reset mid-operation discards the pending write.
        step();
        pipe(6, 64'h66);
        rst_i = 1'b0;
        step();
        pipe_wb_valid_i = 1'b0;
        rst_i = 1'b1;
        step();
        chk("rst_mid_no_we", rf_we_o, 0);
        step();
        step();
        chk("queue_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
